ml_lfsr: RTL and testbench
==========================

# ml_lfsr

Maximal-length Fibonacci LFSR test-pattern generator for the BIST datapath. After reset it emits every non-zero WIDTH-bit pattern exactly once, one pattern per clock. It then raises `complete` and either halts on the final pattern or keeps cycling, depending on `FREE_RUN`. It feeds the circuit-under-test inputs; `complete` tells the BIST controller that the pattern space is exhausted.

## Interface
- `WIDTH`, default 3: register width; supported range 2..16.
- `SEED`, default 1 at index 0, all other bits 0 (3'b100 for WIDTH=3): reset state. A zero SEED is replaced by the default.
- `FREE_RUN`, default 0:
  - 0: halt after one period.
  - 1: keep cycling; `complete` pulses once per period.
- `clock`, input, 1: sole clock, rising-edge.
- `reset`, input, 1: synchronous, active-high.
- `dt_out`, output, [0:WIDTH-1]: current pattern (register state). Index 0 is the feedback/input stage.
- `complete`, output, 1: high while `dt_out` holds the last pattern of a period.
- Port order: `dt_out`, `complete`, `reset`, `clock`.

## Operation
- State `s[0:WIDTH-1]`; `dt_out = s`, driven directly from the flops.
- Shift on every non-halted edge:
  - `s[0] <= XOR of tap bits`
  - `s[i] <= s[i-1]` for i ≥ 1
- Tap table, polynomial exponents k; tap index = k-1:
  - 2:(2,1); 3:(3,2); 4:(4,3); 5:(5,3); 6:(6,5); 7:(7,6)
  - 8:(8,6,5,4); 9:(9,5); 10:(10,7); 11:(11,9); 12:(12,6,4,1)
  - 13:(13,4,3,1); 14:(14,5,3,1); 15:(15,14); 16:(16,15,13,4)
- WIDTH outside 2..16 is a compile-time error.
- WIDTH=3 (taps s[1]^s[2]), sequence from reset: 100, 010, 101, 110, 111, 011, 001, then back to 100. Period is 7.
- Internal pattern counter, WIDTH bits:
  - reset → 1
  - increments with each shift
  - reaches 2^WIDTH-1 on the last pattern
- `complete` is registered. It is set on the edge that loads pattern number 2^WIDTH-1, so it is coincident with that pattern.
- FREE_RUN=0:
  - once `complete`=1, the register and counter hold
  - `complete` stays 1 until reset
- FREE_RUN=1:
  - the next edge returns the register to SEED and the counter to 1, clearing `complete`
  - `complete` is a one-cycle pulse every 2^WIDTH-1 cycles
- Lock-up guard: if the state is ever all-zero (e.g. after an SEU), the next edge loads SEED and the counter to 1.

## Timing
- Reset has priority over everything. The edge that samples reset=1 loads `dt_out`=SEED, counter=1, `complete`=0.
- Reset asserted mid-sequence, or while halted, restarts from SEED on that edge.
- No combinational path from inputs to outputs; latency is one edge per pattern.
- WIDTH=3, reset released before edge E1:
  - SEED is visible from the reset edge until E1
  - E1 → 010, …, E6 → 001 with `complete`=1
  - FREE_RUN=0: E7 onward holds 001 and `complete`=1
  - FREE_RUN=1: E7 → 100 with `complete`=0
- `reset` held high for several cycles: outputs remain SEED with `complete`=0.
- Exactly 2^WIDTH-1 distinct non-zero patterns appear before `complete`. The all-zero pattern is never emitted.

## Test plan
- Defaults, 5 ns half-period clock, `reset`=1 for the first edge then 0:
  - `dt_out` = 100, 010, 101, 110, 111, 011, 001 on consecutive cycles
  - `complete`=0 until 001, then 1
- Defaults, continue 10 more edges: `dt_out` stays 001 and `complete` stays 1.
- Assert `reset` for one edge while `dt_out`=101: next value 100, `complete`=0; the sequence then restarts as in the first scenario.
- FREE_RUN=1, WIDTH=3:
  - `complete` high on exactly cycles 7, 14, 21 after reset
  - `dt_out`=100 on cycles 8, 15
- WIDTH=8, SEED=8'h01, FREE_RUN=0:
  - 255 distinct non-zero values before `complete`=1
  - no repeats; no 8'h00
  - holds afterwards
- Force state to all-zero via hierarchical deposit: next edge `dt_out`=SEED, then the normal sequence continues.

Source files
------------

// File: rtl/ml_lfsr.sv
// ml_lfsr: maximal-length Fibonacci LFSR pattern generator for BIST.
// Emits every non-zero WIDTH-bit pattern once per period, one per clock.
// `complete` marks the last pattern of a period. It either holds there
// (FREE_RUN=0) or restarts from SEED on the following edge (FREE_RUN=1).
// State bit 0 is the feedback/input stage; dt_out mirrors the flops directly.
module ml_lfsr #(
  parameter int               WIDTH    = 3,
  parameter logic [0:WIDTH-1] SEED     = {1'b1, {(WIDTH-1){1'b0}}},
  parameter bit               FREE_RUN = 1'b0
) (
  output logic [0:WIDTH-1] dt_out,
  output logic             complete,
  input  logic             reset,
  input  logic             clock
);

  // Tap positions for each supported width, as state indices (exponent - 1).
  // All polynomials are primitive, so the period is 2^WIDTH - 1.
  function automatic logic [0:15] tap_mask(input int w);
    logic [0:15] m;
    m = '0;
    case (w)
      2:  begin m[1]  = 1'b1; m[0]  = 1'b1; end
      3:  begin m[2]  = 1'b1; m[1]  = 1'b1; end
      4:  begin m[3]  = 1'b1; m[2]  = 1'b1; end
      5:  begin m[4]  = 1'b1; m[2]  = 1'b1; end
      6:  begin m[5]  = 1'b1; m[4]  = 1'b1; end
      7:  begin m[6]  = 1'b1; m[5]  = 1'b1; end
      8:  begin m[7]  = 1'b1; m[5]  = 1'b1; m[4] = 1'b1; m[3] = 1'b1; end
      9:  begin m[8]  = 1'b1; m[4]  = 1'b1; end
      10: begin m[9]  = 1'b1; m[6]  = 1'b1; end
      11: begin m[10] = 1'b1; m[8]  = 1'b1; end
      12: begin m[11] = 1'b1; m[5]  = 1'b1; m[3] = 1'b1; m[0] = 1'b1; end
      13: begin m[12] = 1'b1; m[3]  = 1'b1; m[2] = 1'b1; m[0] = 1'b1; end
      14: begin m[13] = 1'b1; m[4]  = 1'b1; m[2] = 1'b1; m[0] = 1'b1; end
      15: begin m[14] = 1'b1; m[13] = 1'b1; end
      16: begin m[15] = 1'b1; m[14] = 1'b1; m[12] = 1'b1; m[3] = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

  // Unsupported widths have no tap entry; stop elaboration rather than
  // silently build a non-maximal (or degenerate) register.
  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("ml_lfsr: WIDTH must lie in 2..16");
  end

  localparam logic [0:15]        TAPS_ALL     = tap_mask(WIDTH);
  localparam logic [0:WIDTH-1]   TAPS         = TAPS_ALL[0:WIDTH-1];
  localparam logic [0:WIDTH-1]   DEFAULT_SEED = {1'b1, {(WIDTH-1){1'b0}}};
  // A zero seed would lock the register up, so fall back to the default.
  localparam logic [0:WIDTH-1]   SEED_EFF     = (SEED == '0) ? DEFAULT_SEED : SEED;
  localparam logic [WIDTH-1:0]   COUNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   COUNT_LAST   = '1;
  // Counter value on the pattern just before the last one of a period.
  localparam logic [WIDTH-1:0]   COUNT_PRE    = COUNT_LAST - COUNT_ONE;

  logic [0:WIDTH-1] state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             complete_reg, complete_next;
  logic [0:WIDTH-1] tap_bits;
  logic             feedback;
  logic             lockup;

  // Mask each stage with its tap flag; the XOR of the masked bits is the
  // new value entering stage 0.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
    assign tap_bits[gi] = state_reg[gi] & TAPS[gi];
  end

  assign feedback = ^tap_bits;
  assign lockup   = (state_reg == '0);

  // Next-state selection: lock-up recovery, end-of-period handling, or shift.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    complete_next = complete_reg;
    if (lockup) begin
      // All-zero state can only arise from corruption; it would never
      // leave on its own, so restart the period from the seed.
      state_next    = SEED_EFF;
      count_next    = COUNT_ONE;
      complete_next = 1'b0;
    end else if (complete_reg) begin
      if (FREE_RUN) begin
        state_next    = SEED_EFF;
        count_next    = COUNT_ONE;
        complete_next = 1'b0;
      end
      // Otherwise halt: register, counter and complete all hold.
    end else begin
      state_next    = {feedback, state_reg[0:WIDTH-2]};
      count_next    = count_reg + COUNT_ONE;
      // Registered flag lines up with the pattern it describes.
      complete_next = (count_reg == COUNT_PRE);
    end
  end

  // State, pattern counter and complete flag; reset has top priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= SEED_EFF;
      count_reg    <= COUNT_ONE;
      complete_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      complete_reg <= complete_next;
    end
  end

  assign dt_out   = state_reg;
  assign complete = complete_reg;

endmodule

// File: tb/tb_ml_lfsr.sv
// Bench for ml_lfsr: three instances (defaults, free-running, 8-bit) run
// against a pattern-position reference model with directed and random steps.
module tb_ml_lfsr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [0:2] dt_a, dt_b;
  logic [0:7] dt_c;
  logic       comp_a, comp_b, comp_c;

  ml_lfsr u_a (.dt_out(dt_a), .complete(comp_a), .reset(rst_a), .clock(clk));

  ml_lfsr #(.WIDTH(3), .FREE_RUN(1'b1)) u_b (
    .dt_out(dt_b), .complete(comp_b), .reset(rst_b), .clock(clk));

  ml_lfsr #(.WIDTH(8), .SEED(8'h01), .FREE_RUN(1'b0)) u_c (
    .dt_out(dt_c), .complete(comp_c), .reset(rst_c), .clock(clk));

  int checks = 0;
  int errors = 0;

  // Reference: the published WIDTH=3 sequence, indexed by pattern position.
  int seq3 [7] = '{4, 2, 5, 6, 7, 3, 1};
  int pa, pb, pc;          // pattern position 1..period
  logic [7:0] sc;          // 8-bit model pattern, index 0 as MSB
  bit za, zb, zc;          // state forced to zero before the next edge

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 8-bit Fibonacci step from x^8+x^6+x^5+x^4+1: stages 7,5,4,3 feed stage 0.
  function automatic logic [7:0] next8(input logic [7:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[4];   // integer bits of stages 7,5,4,3
    return {fb, s[7:1]};
  endfunction

  task automatic tick();
    logic ra, rb, rc;
    ra = rst_a; rb = rst_b; rc = rst_c;
    @(posedge clk);
    #1;
    if (ra || za) pa = 1; else if (pa != 7) pa = pa + 1;
    if (rb || zb) pb = 1; else pb = (pb == 7) ? 1 : pb + 1;
    if (rc || zc) begin pc = 1; sc = 8'h01; end
    else if (pc != 255) begin pc = pc + 1; sc = next8(sc); end
    za = 0; zb = 0; zc = 0;
    chk("a_dt",   32'(dt_a),   32'(seq3[pa-1]));
    chk("a_comp", 32'(comp_a), 32'(pa == 7));
    chk("b_dt",   32'(dt_b),   32'(seq3[pb-1]));
    chk("b_comp", 32'(comp_b), 32'(pb == 7));
    chk("c_dt",   32'(dt_c),   32'(sc));
    chk("c_comp", 32'(comp_c), 32'(pc == 255));
    $display("t=%0t a=%b/%b b=%b/%b c=%h/%b", $time, dt_a, comp_a, dt_b, comp_b, dt_c, comp_c);
  endtask

  task automatic zero_a();
    force u_a.state_reg = '0; #1; release u_a.state_reg; za = 1;
  endtask
  task automatic zero_b();
    force u_b.state_reg = '0; #1; release u_b.state_reg; zb = 1;
  endtask
  task automatic zero_c();
    force u_c.state_reg = '0; #1; release u_c.state_reg; zc = 1;
  endtask

  bit seen [256];
  int distinct, dups, zeros, budget;
  int cyc_b;

  initial begin
    pa = 1; pb = 1; pc = 1; sc = 8'h01;
    za = 0; zb = 0; zc = 0;
    rst_a = 1; rst_b = 1; rst_c = 1;

    // Reset held for several edges: outputs sit at the seed.
    repeat (3) tick();
    rst_a = 0; rst_b = 0;

    // Free-running instance: complete on cycles 7,14,21; seed on 8,15.
    cyc_b = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      cyc_b = cyc_b + 1;
      chk("b_comp_cycle", 32'(comp_b), 32'((cyc_b + 1) % 7 == 0));
      if ((cyc_b + 1) % 7 == 1) chk("b_seed_cycle", 32'(dt_b), 32'd4);
    end
    // Defaults instance must now be parked on 001 with complete high.
    chk("a_halt_dt", 32'(dt_a), 32'd1);
    chk("a_halt_comp", 32'(comp_a), 32'd1);

    // Restart a, run to 101, then pulse reset for one edge.
    rst_a = 1; tick(); rst_a = 0;
    budget = 0;
    while (dt_a != 3'b101 && budget < 20) begin tick(); budget++; end
    chk("a_reach_101", 32'(dt_a), 32'd5);
    rst_a = 1; tick(); rst_a = 0;
    chk("a_midreset_dt", 32'(dt_a), 32'd4);
    repeat (7) tick();

    // Lock-up recovery on each instance.
    zero_a(); zero_b(); tick();
    chk("a_lockup_seed", 32'(dt_a), 32'd4);
    chk("b_lockup_seed", 32'(dt_b), 32'd4);
    repeat (3) tick();

    // 8-bit instance: full period, distinct non-zero values, then hold.
    rst_c = 1; tick(); rst_c = 0;
    foreach (seen[i]) seen[i] = 0;
    seen[dt_c] = 1; distinct = 1; dups = 0; zeros = 0; budget = 0;
    while (!comp_c && budget < 300) begin
      tick(); budget++;
      if (dt_c == 8'h00) zeros++;
      if (seen[dt_c]) dups++; else distinct++;
      seen[dt_c] = 1;
    end
    chk("c_distinct", 32'(distinct), 32'd255);
    chk("c_dups", 32'(dups), 32'd0);
    chk("c_zeros", 32'(zeros), 32'd0);
    repeat (5) tick();
    zero_c(); tick();
    chk("c_lockup_seed", 32'(dt_c), 32'h01);

    // Random phase: sporadic resets and lock-up injections on all instances.
    for (int i = 0; i < 400; i++) begin
      rst_a = ($urandom_range(0, 39) == 0);
      rst_b = ($urandom_range(0, 39) == 0);
      rst_c = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) zero_a();
      if ($urandom_range(0, 49) == 0) zero_b();
      if ($urandom_range(0, 99) == 0) zero_c();
      tick();
    end
    rst_a = 0; rst_b = 0; rst_c = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
